// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin QSPI bus arbiter: FSM state codes,
// transfer-size encoding and the channel-index width helper.
package bus_arbiter_rr_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_TURN    = 2'd3;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_HW = 2'd1,
    SZ_W  = 2'd2
  } size_e;

  // Word takes precedence if a master raises both size flags.
  function automatic size_e encodeSize(input logic w, input logic hw);
    size_e sz;
    sz = SZ_B;
    if (w) begin
      sz = SZ_W;
    end else if (hw) begin
      sz = SZ_HW;
    end
    return sz;
  endfunction

  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requesting channel at or after
// the pointer, wrapping modulo NCH.
module bus_arbiter_rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic           o_valid,
  output logic [IW-1:0]  o_idx
);

  // One spare bit so ptr+k never overflows before the explicit wrap compare.
  logic [IW:0] w_cand;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NCH)) begin
        w_cand = w_cand - (IW+1)'(NCH);
      end
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel round-robin arbiter merging master read/write requests onto the
// single QSPI port, one transaction outstanding, with per-channel timeout.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 4096,
  localparam int IW    = idxWidth(NCH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_ch_read_req,
  input  logic [NCH-1:0]    i_ch_read_w,
  input  logic [NCH-1:0]    i_ch_read_hw,
  input  logic [NCH*AW-1:0] i_ch_read_adr,
  input  logic [NCH-1:0]    i_ch_write_req,
  input  logic [NCH-1:0]    i_ch_write_w,
  input  logic [NCH-1:0]    i_ch_write_hw,
  input  logic [NCH*AW-1:0] i_ch_write_adr,
  input  logic [NCH*DW-1:0] i_ch_write_data,
  output logic [NCH-1:0]    o_ch_read_done,
  output logic [NCH-1:0]    o_ch_write_done,
  output logic [NCH-1:0]    o_ch_err,
  output logic [DW-1:0]     o_ch_read_data,
  output logic              o_read_req,
  output logic              o_read_w,
  output logic              o_read_hw,
  output logic [AW-1:0]     o_read_adr,
  input  logic              i_read_valid,
  input  logic [DW-1:0]     i_read_data,
  output logic              o_write_req,
  output logic              o_write_w,
  output logic              o_write_hw,
  output logic [AW-1:0]     o_write_adr,
  output logic [DW-1:0]     o_write_data,
  input  logic              i_write_finish,
  output logic              o_busy,
  output logic [IW-1:0]     o_grant_id
);

  localparam int            CW      = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  logic [1:0]     r_state;
  logic [IW-1:0]  r_ptr;
  logic [IW-1:0]  r_grant;
  logic [CW-1:0]  r_cnt;
  logic           r_readReq;
  logic           r_writeReq;
  logic           r_busy;
  size_e          r_rdSize;
  size_e          r_wrSize;
  logic [AW-1:0]  r_rdAdr;
  logic [AW-1:0]  r_wrAdr;
  logic [DW-1:0]  r_wrData;
  logic [DW-1:0]  r_rdData;
  logic [NCH-1:0] r_rdDone;
  logic [NCH-1:0] r_wrDone;
  logic [NCH-1:0] r_err;

  logic           w_pickValid;
  logic [IW-1:0]  w_pickIdx;
  logic           w_pickRead;
  logic [IW-1:0]  w_nextPtr;
  logic           w_timeout;
  logic [NCH-1:0] w_grantOh;

  bus_arbiter_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .i_req   (i_ch_read_req | i_ch_write_req),
    .i_ptr   (r_ptr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  assign w_pickRead = i_ch_read_req[w_pickIdx];
  assign w_nextPtr  = (r_grant == IW'(NCH - 1)) ? '0 : r_grant + 1'b1;
  assign w_timeout  = (TO_CYC > 0) && (r_cnt == TO_LAST);
  assign w_grantOh  = NCH'(1) << r_grant;

  // Completion strobes are only honoured in the matching WAIT state and win over timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_readReq  <= 1'b0;
      r_writeReq <= 1'b0;
      r_busy     <= 1'b0;
      r_rdSize   <= SZ_B;
      r_wrSize   <= SZ_B;
      r_rdAdr    <= '0;
      r_wrAdr    <= '0;
      r_wrData   <= '0;
      r_rdData   <= '0;
      r_rdDone   <= '0;
      r_wrDone   <= '0;
      r_err      <= '0;
    end else begin
      r_readReq  <= 1'b0;
      r_writeReq <= 1'b0;
      r_rdDone   <= '0;
      r_wrDone   <= '0;
      r_err      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pickValid) begin
            r_grant <= w_pickIdx;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            if (w_pickRead) begin
              r_readReq <= 1'b1;
              r_rdAdr   <= i_ch_read_adr[w_pickIdx*AW +: AW];
              r_rdSize  <= encodeSize(i_ch_read_w[w_pickIdx], i_ch_read_hw[w_pickIdx]);
              r_state   <= ST_RD_WAIT;
            end else begin
              r_writeReq <= 1'b1;
              r_wrAdr    <= i_ch_write_adr[w_pickIdx*AW +: AW];
              r_wrData   <= i_ch_write_data[w_pickIdx*DW +: DW];
              r_wrSize   <= encodeSize(i_ch_write_w[w_pickIdx], i_ch_write_hw[w_pickIdx]);
              r_state    <= ST_WR_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (i_read_valid) begin
            r_rdDone <= w_grantOh;
            r_rdData <= i_read_data;
            r_busy   <= 1'b0;
            r_ptr    <= w_nextPtr;
            r_state  <= ST_TURN;
          end else if (w_timeout) begin
            r_err   <= w_grantOh;
            r_busy  <= 1'b0;
            r_ptr   <= w_nextPtr;
            r_state <= ST_TURN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (i_write_finish) begin
            r_wrDone <= w_grantOh;
            r_busy   <= 1'b0;
            r_ptr    <= w_nextPtr;
            r_state  <= ST_TURN;
          end else if (w_timeout) begin
            r_err   <= w_grantOh;
            r_busy  <= 1'b0;
            r_ptr   <= w_nextPtr;
            r_state <= ST_TURN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ch_read_done  = r_rdDone;
  assign o_ch_write_done = r_wrDone;
  assign o_ch_err        = r_err;
  assign o_ch_read_data  = r_rdData;
  assign o_read_req      = r_readReq;
  assign o_read_w        = (r_rdSize == SZ_W);
  assign o_read_hw       = (r_rdSize == SZ_HW);
  assign o_read_adr      = r_rdAdr;
  assign o_write_req     = r_writeReq;
  assign o_write_w       = (r_wrSize == SZ_W);
  assign o_write_hw      = (r_wrSize == SZ_HW);
  assign o_write_adr     = r_wrAdr;
  assign o_write_data    = r_wrData;
  assign o_busy          = r_busy;
  assign o_grant_id      = r_grant;

endmodule
